quadratic_inverse_search: RTL and testbench
===========================================

// Module: quadratic_inverse_search
// PURPOSE
//  Sequential inverse of the quadratic evaluator q(x) = A*x**2 + B*x + C.
//  Takes a signed target y and returns the signed x whose q(x) is nearest to y.
//  It searches all 2**W_X candidates, one per clock, instead of storing a
//  2**W_Y-entry inverse LUT.
//  It sits behind a valid/ready request port and in front of a valid/ready result port.
// PARAMETERS
//  W_X  4    width of signed x (candidate / result)
//  W_Y  8    width of signed y (target / q(x))
//  A    1    quadratic coefficient (signed)
//  B    10   linear coefficient (signed)
//  C    -10  constant term (signed)
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      reset, synchronous and active-high
//  s_valid  in   1      request valid
//  s_ready  out  1      request ready; high only in IDLE
//  s_y      in   W_Y    signed target y, sampled on s_valid&&s_ready
//  m_valid  out  1      result valid
//  m_ready  in   1      result ready
//  m_x      out  W_X    signed best x
//  m_err    out  W_Y+1  unsigned |y - q(m_x)|
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - state=IDLE; m_valid=0; m_x=0; m_err=0; the counter and best registers are cleared.
//    - This applies from any state; an in-flight search is discarded and no result is produced.
//  - FSM IDLE -> SEARCH -> DONE -> IDLE:
//    - IDLE: s_ready=1. On s_valid=1, latch s_y, set cnt=0 and min_err=2**W_Y, go to SEARCH.
//    - SEARCH: s_ready=0. Each cycle evaluate candidate x = signed(cnt[W_X-1:0]).
//      - Candidate order is unsigned 0..2**W_X-1, i.e. 0,1,..,7,-8,..,-1 for W_X=4.
//      - After the candidate with cnt = 2**W_X-1, go to DONE.
//    - DONE: m_valid=1 and s_ready=0. On m_ready=1, clear m_valid and go to IDLE.
//  - q(x) arithmetic:
//    - Evaluate in 32-bit signed arithmetic, then truncate to W_Y bits and reinterpret as signed.
//    - Wrap-around on truncation is intended.
//  - Error: err = |sext(y) - sext(q)| in 32-bit signed, held in W_Y+1 bits unsigned.
//  - Update rule: if err < min_err (strict), set min_err=err and best_x=x.
//    - Ties keep the earlier candidate in search order.
//  - Latency: m_valid rises 2**W_X+1 cycles after the accept edge (17 for W_X=4).
//    - The last search update and the DONE transition happen on the same edge.
//  - Throughput: one request per 2**W_X+2 cycles minimum.
//    - A new request cannot be accepted in the same cycle as m_ready.
//  - Backpressure: m_x and m_err stay stable while m_valid && !m_ready.
//    - s_valid is ignored (s_ready=0) for the whole busy period.
//  - m_x and m_err are written only on entry to DONE; they hold their value in IDLE.
//  - Simultaneous rst with s_valid or m_ready: rst wins.
// TESTING (defaults A=1, B=10, C=-10; q: 0->-10, 1->1, 2->14, -5->-35, 7->109)
//  1. Reset, then s_y=1
//     -> s_ready=1 before the request, then m_valid 17 cycles after accept;
//        m_x=1, m_err=0.
//  2. s_y=-34 (tie between x=-6 and x=-4)
//     -> m_x=-6, m_err=0.
//     s_y=-26 (tie between x=-8 and x=-2)
//     -> m_x=-8, m_err=0.
//  3. Boundary targets:
//     s_y=127 -> m_x=7, m_err=18.
//     s_y=-128 -> m_x=-5, m_err=93.
//     s_y=8 -> m_x=2, m_err=6.
//  4. Hold m_ready=0 for 10 cycles after m_valid
//     -> m_valid, m_x and m_err stay stable; s_ready=0.
//     Pulse s_valid while busy -> the request is not accepted.
//  5. Assert rst 5 cycles into SEARCH
//     -> next cycle: IDLE, m_valid=0, s_ready=1.
//     A fresh s_y=1 then yields m_x=1 with normal latency.
//  6. Back-to-back requests with m_ready tied high, s_valid held
//     -> accepts are spaced exactly 18 cycles apart; results match the golden
//        brute-force model for 100 random y.

Source files
------------

// File: rtl/quadratic_inverse_search.sv
// quadratic_inverse_search: finds the signed x whose q(x) = A*x^2 + B*x + C is
// nearest to a requested signed y by sweeping every x candidate, one per clock.
// The accept edge starts the sweep. The last candidate's update and the entry
// to DONE happen on the same edge, so m_valid is high after the 17th edge,
// counting the accept edge as the first (W_X=4).
module quadratic_inverse_search #(
  parameter int        W_X = 4,
  parameter int        W_Y = 8,
  parameter int signed A   = 1,
  parameter int signed B   = 10,
  parameter int signed C   = -10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W_Y-1:0] s_y,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W_X-1:0] m_x,
  output logic [W_Y:0]   m_err
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t         state_q, state_d;
  logic [W_X-1:0] cnt_q, cnt_d;
  logic [W_Y-1:0] y_q, y_d;
  logic [W_Y:0]   min_err_q, min_err_d;
  logic [W_X-1:0] best_x_q, best_x_d;
  logic [W_X-1:0] m_x_q, m_x_d;
  logic [W_Y:0]   m_err_q, m_err_d;

  logic signed [31:0] x32, q32, y32, diff32;
  logic [W_Y-1:0]     q_t;
  logic [W_Y:0]       err;
  logic               upd;

  // Candidate evaluation: 32-bit signed q(x), wrapped to W_Y bits, then |y - q|.
  always_comb begin
    x32    = {{(32-W_X){cnt_q[W_X-1]}}, cnt_q};
    q_t    = W_Y'(A * x32 * x32 + B * x32 + C);
    q32    = {{(32-W_Y){q_t[W_Y-1]}}, q_t};
    y32    = {{(32-W_Y){y_q[W_Y-1]}}, y_q};
    diff32 = y32 - q32;
    err    = (W_Y+1)'((diff32 < 0) ? -diff32 : diff32);
    // Strict compare: ties keep the earlier candidate in sweep order.
    upd    = (err < min_err_q);
  end

  // Next-state and datapath control for IDLE -> SEARCH -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    min_err_d = min_err_q;
    best_x_d  = best_x_q;
    m_x_d     = m_x_q;
    m_err_d   = m_err_q;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          y_d       = s_y;
          cnt_d     = '0;
          min_err_d = {1'b1, {W_Y{1'b0}}};
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        cnt_d = cnt_q + 1'b1;
        if (upd) begin
          min_err_d = err;
          best_x_d  = cnt_q;
        end
        // The final candidate's update is folded straight into the result.
        if (cnt_q == {W_X{1'b1}}) begin
          m_x_d   = upd ? cnt_q : best_x_q;
          m_err_d = upd ? err   : min_err_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      min_err_q <= '0;
      best_x_q  <= '0;
      m_x_q     <= '0;
      m_err_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      min_err_q <= min_err_d;
      best_x_q  <= best_x_d;
      m_x_q     <= m_x_d;
      m_err_q   <= m_err_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign m_x     = m_x_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_quadratic_inverse_search.sv
// Directed bench for quadratic_inverse_search (A=1, B=10, C=-10, W_X=4, W_Y=8).
module tb_quadratic_inverse_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_y;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_x;
  logic [8:0] m_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  quadratic_inverse_search dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_y     (s_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x     (m_x),
    .m_err   (m_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent brute-force reference: wrap q to 8-bit signed, keep first minimum.
  function automatic void golden(input int y, output int bx, output int be);
    be = 256;
    bx = 0;
    for (int u = 0; u < 16; u++) begin
      int x, q, e;
      x = (u > 7) ? u - 16 : u;
      q = x * x + 10 * x - 10;
      q = q & 255;
      if (q >= 128) q = q - 256;
      e = (y > q) ? y - q : q - y;
      if (e < be) begin
        be = e;
        bx = x;
      end
    end
  endfunction

  // Issue one request, measure latency, check result and handshake back to IDLE.
  task automatic do_req(input string tag, input int y, input int ex, input int ee);
    int lat;
    s_y     = 8'(y);
    s_valid = 1'b1;
    check({tag, "_s_ready"}, int'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 17);
    check({tag, "_m_x"}, int'($signed(m_x)), ex);
    check({tag, "_m_err"}, int'(m_err), ee);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({tag, "_m_valid_clr"}, int'(m_valid), 0);
    check({tag, "_idle"}, int'(s_ready), 1);
  endtask

  initial begin
    int lat, hx, he, prev, gx, ge;
    int ys[100];
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_y = '0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset state, then a simple request
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_x", int'(m_x), 0);
    check("rst_m_err", int'(m_err), 0);
    do_req("y1", 1, 1, 0);

    // 2. ties keep the earlier candidate in sweep order
    do_req("tie_m34", -34, -6, 0);
    do_req("tie_m26", -26, -8, 0);

    // 3. boundary targets
    do_req("y127", 127, 7, 18);
    do_req("ym128", -128, -5, 93);
    do_req("y8", 8, 2, 6);

    // 4. busy-period s_valid ignored, backpressure holds the result
    s_y = 8'sd127; s_valid = 1'b1;
    tick();
    s_y = 8'h80;
    for (int i = 0; i < 4; i++) tick();
    check("busy_s_ready", int'(s_ready), 0);
    s_valid = 1'b0;
    lat = 5;
    while (!m_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 17);
    hx = int'($signed(m_x));
    he = int'(m_err);
    check("bp_m_x", hx, 7);
    check("bp_m_err", he, 18);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin s_valid = 1'b1; s_y = 8'd1; end
      if (i == 5) s_valid = 1'b0;
      tick();
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_x_hold", int'($signed(m_x)), 7);
      check("bp_m_err_hold", int'(m_err), 18);
      check("bp_s_ready", int'(s_ready), 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("bp_release_idle", int'(s_ready), 1);
    tick(); tick();
    check("bp_no_new_req", int'(s_ready), 1);
    check("bp_m_x_idle", int'($signed(m_x)), 7);

    // 5. reset in the middle of a search
    s_y = 8'd1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_m_valid", int'(m_valid), 0);
    check("mid_rst_s_ready", int'(s_ready), 1);
    check("mid_rst_m_x", int'(m_x), 0);
    check("mid_rst_m_err", int'(m_err), 0);
    do_req("post_rst_y1", 1, 1, 0);

    // 6. back-to-back with m_ready high and s_valid held
    for (int i = 0; i < 100; i++) ys[i] = int'($signed(8'($urandom_range(255))));
    ys[0] = 127; ys[1] = -128;
    m_ready = 1'b1;
    s_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      s_y = 8'(ys[i]);
      lat = 0;
      while (!s_ready && lat < 40) begin
        tick();
        lat++;
      end
      if (!s_ready) check("b2b_ready_timeout", 0, 1);
      @(posedge clk);
      if (i > 0) check("b2b_spacing", cyc - prev, 18);
      prev = cyc;
      #1;
      lat = 1;
      while (!m_valid && lat < 40) begin
        tick();
        lat++;
      end
      golden(ys[i], gx, ge);
      check("b2b_latency", lat, 17);
      check("b2b_m_x", int'($signed(m_x)), gx);
      check("b2b_m_err", int'(m_err), ge);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
